// File: rtl/apb_pkg.sv
// Shared types and default widths for the queued APB4 master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

  localparam int APB_ADDR_W     = 32;
  localparam int APB_DATA_W     = 32;
  localparam int APB_STRB_W     = APB_DATA_W / 8;
  localparam int APB_NUM_SLAVES = 4;
  localparam int APB_FIFO_DEPTH = 4;
  localparam int APB_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  // Command as queued, at the default widths.
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
  } apb_cmd_t;

  // Width of the slave index; a single slave still gets one (unused) bit.
  function automatic int sel_bits(input int num_slaves);
    return (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// In-order command queue, DEPTH entries of WIDTH bits, no bypass.
// Latency: a push is visible at the head (empty = 0) the cycle after its edge.
// Backpressure: push_rdy is registered !full, held low through reset.
module apb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_rdy,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && push_rdy;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  // Occupancy after this edge; simultaneous push and pop cancel out.
  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      push_rdy <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count    <= count_nxt;
      push_rdy <= (count_nxt != CW'(DEPTH));
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/apb4_master_q.sv
// Queued APB4 master: commands in, one-cycle response pulses out, in order.
// Latency: idle accept at edge t -> SETUP t+1, ACCESS t+2, rsp_valid after t+3 (+ wait states).
// Backpressure: cmd_ready = queue not full; responses are never stalled.
module apb4_master_q
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_W,
  parameter int DATA_WIDTH = APB_DATA_W,
  parameter int NUM_SLAVES = APB_NUM_SLAVES,
  parameter int FIFO_DEPTH = APB_FIFO_DEPTH,
  parameter int TIMEOUT    = APB_TIMEOUT
) (
  input  logic                             Pclk,
  input  logic                             Preset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_write,
  input  logic [ADDR_WIDTH-1:0]            cmd_addr,
  input  logic [DATA_WIDTH-1:0]            cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]          cmd_strb,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             rsp_timeout,
  output logic [ADDR_WIDTH-1:0]            Paddr,
  output logic [DATA_WIDTH-1:0]            Pwdata,
  output logic [DATA_WIDTH/8-1:0]          Pstrb,
  output logic                             Pwrite,
  output logic [NUM_SLAVES-1:0]            Psel,
  output logic                             Penable,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] Prdata_in,
  input  logic [NUM_SLAVES-1:0]            Pready,
  input  logic [NUM_SLAVES-1:0]            Pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SB     = sel_bits(NUM_SLAVES);
  localparam int WCW    = $clog2(TIMEOUT + 1);

  // Same layout as apb_cmd_t, sized by this instance's parameters.
  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     strb;
  } cmd_t;

  cmd_t                  push_cmd;
  cmd_t                  head;
  logic                  fifo_empty;
  logic                  pop;
  apb_state_t            state;
  apb_state_t            state_nxt;
  logic [SB-1:0]         head_idx;
  logic [SB-1:0]         sel_idx;
  logic [WCW-1:0]        wait_cnt;
  logic [DATA_WIDTH-1:0] rdata_arr [NUM_SLAVES];
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  done;
  logic                  expire;

  // Pack the incoming command for the queue.
  always_comb begin
    push_cmd       = '0;
    push_cmd.write = cmd_write;
    push_cmd.addr  = cmd_addr;
    push_cmd.wdata = cmd_wdata;
    push_cmd.strb  = cmd_strb;
  end

  apb_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (Pclk),
    .rst      (Preset),
    .push     (cmd_valid),
    .push_dat (push_cmd),
    .push_rdy (cmd_ready),
    .pop      (pop),
    .pop_dat  (head),
    .empty    (fifo_empty)
  );

  // Slave index comes from the top address bits; a lone slave is always index 0.
  if (NUM_SLAVES > 1) begin : g_idx
    assign head_idx = head.addr[ADDR_WIDTH-1 -: SB];
  end else begin : g_idx_one
    assign head_idx = '0;
  end

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_rdata
    assign rdata_arr[i] = Prdata_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Only the registered target slave is listened to.
  assign sel_ready = Pready[sel_idx];
  assign sel_err   = Pslverr[sel_idx];
  assign sel_rdata = rdata_arr[sel_idx];

  // Pready wins over the watchdog in the cycle the limit is reached.
  assign done   = (state == ST_ACCESS) && sel_ready;
  assign expire = (state == ST_ACCESS) && !sel_ready && (wait_cnt == WCW'(TIMEOUT - 1));

  // Next state and queue pop; a completion with work pending goes straight to SETUP.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_nxt = ST_SETUP;
          pop       = 1'b1;
        end
      end
      ST_SETUP: state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (done) begin
          if (!fifo_empty) begin
            state_nxt = ST_SETUP;
            pop       = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (expire) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Pclk) begin
    if (Preset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Address-phase registers load only on pop, so they hold through ACCESS.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      Paddr   <= '0;
      Pwdata  <= '0;
      Pstrb   <= '0;
      Pwrite  <= 1'b0;
      sel_idx <= '0;
    end else if (pop) begin
      Paddr   <= head.addr;
      Pwrite  <= head.write;
      Pstrb   <= head.write ? head.strb : '0;
      sel_idx <= head_idx;
      if (head.write) Pwdata <= head.wdata;
    end
  end

  // Wait-state counter: cleared in SETUP, counts ACCESS cycles without Pready.
  always_ff @(posedge Pclk) begin
    if (Preset)                                wait_cnt <= '0;
    else if (state == ST_SETUP)                wait_cnt <= '0;
    else if (state == ST_ACCESS && !sel_ready) wait_cnt <= wait_cnt + WCW'(1);
  end

  // Response pulse for a completion or a watchdog abort.
  always_ff @(posedge Pclk) begin
    if (Preset) begin
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid   <= done || expire;
      rsp_err     <= done ? sel_err : expire;
      rsp_timeout <= expire;
      rsp_rdata   <= (done && !Pwrite) ? sel_rdata : '0;
    end
  end

  // One-hot select outside IDLE; Penable marks the access phase.
  always_comb begin
    Psel = '0;
    if (state != ST_IDLE) Psel[sel_idx] = 1'b1;
  end

  assign Penable = (state == ST_ACCESS);

endmodule

// File: tb/tb_apb4_master_q.sv
// Bench for apb4_master_q: directed scenarios plus random traffic against a queue model.
// Every negedge one process checks outputs, drives the slaves and offers commands.
// Each command carries its own slave behaviour (wait states, error, read data).
module tb_apb4_master_q;
  import apb_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int NS    = 4;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int SW    = DW / 8;

  logic             Pclk = 1'b0;
  logic             Preset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_write = 1'b0;
  logic [AW-1:0]    cmd_addr = '0;
  logic [DW-1:0]    cmd_wdata = '0;
  logic [SW-1:0]    cmd_strb = '0;
  logic             rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic             rsp_timeout;
  logic [AW-1:0]    Paddr;
  logic [DW-1:0]    Pwdata;
  logic [SW-1:0]    Pstrb;
  logic             Pwrite;
  logic [NS-1:0]    Psel;
  logic             Penable;
  logic [NS*DW-1:0] Prdata_in = '0;
  logic [NS-1:0]    Pready = '0;
  logic [NS-1:0]    Pslverr = '0;

  apb4_master_q #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_SLAVES (NS),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .Pclk        (Pclk),
    .Preset      (Preset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_strb    (cmd_strb),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .Paddr       (Paddr),
    .Pwdata      (Pwdata),
    .Pstrb       (Pstrb),
    .Pwrite      (Pwrite),
    .Psel        (Psel),
    .Penable     (Penable),
    .Prdata_in   (Prdata_in),
    .Pready      (Pready),
    .Pslverr     (Pslverr)
  );

  initial forever #5 Pclk = ~Pclk;

  typedef struct {
    apb_cmd_t    cmd;
    int          wt;     // ACCESS cycles before Pready; >= TMO means never in time
    logic        err;
    logic [31:0] rdata;
    bit          lat;    // issued from idle: check end-to-end latency
    int          acc_edge;
  } stim_t;

  stim_t       stim_q[$];
  stim_t       pend_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          accepted = 0;
  int          started = 0;
  int          occ_prev = 0;
  int          acc = 0;
  int          full_seen = 0;
  int          valid_pct = 100;
  int          rst_cnt = 1;
  bit          rst_seen = 1'b1;
  bit          sent_last = 1'b0;
  logic [31:0] last_wdata = '0;

  initial forever begin
    @(posedge Pclk);
    cyc++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [NS-1:0] onehot(input logic [31:0] a);
    logic [NS-1:0] v;
    v = '0;
    v[a[31:30]] = 1'b1;
    return v;
  endfunction

  // Reference outcome of one command from its slave behaviour.
  function automatic void model(input stim_t s, output logic err, output logic to,
                                output logic [31:0] rd, output int ncyc);
    if (s.wt >= TMO) begin
      err = 1'b1; to = 1'b1; rd = '0; ncyc = TMO;
    end else begin
      err = s.err; to = 1'b0; rd = s.cmd.write ? 32'h0 : s.rdata; ncyc = s.wt + 1;
    end
  endfunction

  function automatic logic [72:0] phase_exp(input stim_t s);
    return {s.cmd.addr, last_wdata, (s.cmd.write ? s.cmd.strb : 4'h0), s.cmd.write, onehot(s.cmd.addr)};
  endfunction

  task automatic monitor();
    stim_t       p;
    logic        e_err;
    logic        e_to;
    logic [31:0] e_rd;
    int          e_cyc;
    int          occ_cur;
    if (rsp_valid) begin
      check("rsp_pending", pend_q.size() != 0, 1'b1);
      if (pend_q.size() != 0) begin
        p = pend_q.pop_front();
        model(p, e_err, e_to, e_rd, e_cyc);
        check("rsp", {rsp_err, rsp_timeout, rsp_rdata}, {e_err, e_to, e_rd});
        check("access_cycles", acc, e_cyc);
        if (p.lat) check("latency", cyc - p.acc_edge, 2 + e_cyc);
        check("next_phase", {Psel != '0, Penable}, {(!e_to && occ_prev != 0), 1'b0});
      end
      acc = 0;
    end
    if (Psel != '0 && !Penable) begin
      started++;
      check("setup_pending", pend_q.size() != 0, 1'b1);
      if (pend_q.size() != 0) begin
        p = pend_q[0];
        if (p.cmd.write) last_wdata = p.cmd.wdata;
        check("setup", {Paddr, Pwdata, Pstrb, Pwrite, Psel}, phase_exp(p));
      end
    end
    if (Penable) begin
      check("access_pending", pend_q.size() != 0, 1'b1);
      if (pend_q.size() != 0) check("access", {Paddr, Pwdata, Pstrb, Pwrite, Psel}, phase_exp(pend_q[0]));
    end
    occ_cur = accepted - started;
    check("cmd_ready", cmd_ready, occ_cur < DEPTH);
    if (!cmd_ready) full_seen++;
    occ_prev = occ_cur;
  endtask

  task automatic offer();
    stim_t s;
    if (sent_last) cmd_valid = 1'b0;
    sent_last = 1'b0;
    if (!cmd_valid && stim_q.size() != 0 && $urandom_range(99) < valid_pct) begin
      s = stim_q[0];
      cmd_valid = 1'b1;
      cmd_write = s.cmd.write;
      cmd_addr  = s.cmd.addr;
      cmd_wdata = s.cmd.wdata;
      cmd_strb  = s.cmd.strb;
    end else if (!cmd_valid) begin
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_strb  = 4'($urandom);
    end
    if (cmd_valid && cmd_ready) begin
      s = stim_q.pop_front();
      s.acc_edge = cyc + 1;
      pend_q.push_back(s);
      accepted++;
      sent_last = 1'b1;
    end
  endtask

  // Unselected slaves get random noise; the selected one follows the command's plan.
  task automatic drive_slaves();
    int si;
    Pready  = 4'($urandom);
    Pslverr = 4'($urandom);
    for (int i = 0; i < NS; i++) Prdata_in[i*DW +: DW] = $urandom;
    if (Penable && !Preset && pend_q.size() != 0) begin
      si = int'(pend_q[0].cmd.addr[31:30]);
      Pready[si]  = (acc == pend_q[0].wt);
      Pslverr[si] = pend_q[0].err;
      Prdata_in[si*DW +: DW] = pend_q[0].rdata;
      acc++;
    end
  endtask

  initial forever begin
    @(negedge Pclk);
    if (rst_seen) begin
      check("reset_outputs",
            {cmd_ready, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, Paddr, Pwdata, Pstrb, Pwrite, Psel, Penable},
            128'h0);
    end else begin
      monitor();
    end
    if (rst_cnt > 0) begin
      Preset = 1'b1;
      rst_cnt--;
      stim_q.delete();
      pend_q.delete();
      accepted = 0; started = 0; occ_prev = 0; acc = 0;
      last_wdata = '0;
      cmd_valid = 1'b0;
      sent_last = 1'b0;
    end else begin
      Preset = 1'b0;
      offer();
    end
    drive_slaves();
    rst_seen = Preset;
  end

  task automatic add(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                     input int wt, input logic err, input logic [31:0] rd, input bit lat);
    stim_t s;
    s.cmd.write = w;
    s.cmd.addr  = a;
    s.cmd.wdata = wd;
    s.cmd.strb  = st;
    s.wt        = wt;
    s.err       = err;
    s.rdata     = rd;
    s.lat       = lat;
    s.acc_edge  = 0;
    stim_q.push_back(s);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((stim_q.size() != 0 || pend_q.size() != 0 || cmd_valid) && n < budget) begin
      @(posedge Pclk);
      #1;
      n++;
    end
    check("drain", stim_q.size() + pend_q.size(), 0);
    repeat (2) @(posedge Pclk);
    #1;
  endtask

  initial begin
    int r;
    int wt;
    int n;
    repeat (4) @(posedge Pclk);
    #1;

    // Single zero-wait write to slave 0.
    add(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0, 1'b1);
    wait_idle(50);

    // Read from slave 1 with three wait states.
    add(1'b0, 32'h4000_0004, 32'h0, 4'hF, 3, 1'b0, 32'h1234_5678, 1'b1);
    wait_idle(50);

    // Five back-to-back commands; the first is slow so the queue fills.
    full_seen = 0;
    add(1'b1, 32'h0000_0100, 32'hA5A5_0001, 4'h3, 3, 1'b0, 32'h0, 1'b0);
    add(1'b0, 32'h4000_0104, 32'h0, 4'hF, 0, 1'b0, 32'hCAFE_0002, 1'b0);
    add(1'b1, 32'h8000_0108, 32'hA5A5_0003, 4'hC, 1, 1'b0, 32'h0, 1'b0);
    add(1'b0, 32'hC000_010C, 32'h0, 4'h1, 0, 1'b0, 32'hCAFE_0004, 1'b0);
    add(1'b0, 32'h0000_0110, 32'h0, 4'hF, 2, 1'b0, 32'hCAFE_0005, 1'b0);
    wait_idle(100);
    check("queue_filled", full_seen != 0, 1'b1);

    // Watchdog on slave 2, then a queued command must still run.
    add(1'b0, 32'h8000_0000, 32'h0, 4'hF, 99, 1'b0, 32'h1111_1111, 1'b1);
    add(1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'h5, 0, 1'b0, 32'h0, 1'b0);
    wait_idle(100);

    // Pready on the last allowed cycle completes; one cycle later it has timed out.
    add(1'b0, 32'h4000_0040, 32'h0, 4'hF, TMO - 1, 1'b0, 32'h7777_0001, 1'b1);
    wait_idle(100);
    add(1'b0, 32'h4000_0044, 32'h0, 4'hF, TMO, 1'b0, 32'h7777_0002, 1'b1);
    wait_idle(100);

    // Slave error on slave 3 does not flush later commands.
    add(1'b0, 32'hC000_0008, 32'h0, 4'hF, 0, 1'b1, 32'h5555_AAAA, 1'b0);
    add(1'b1, 32'hC000_000C, 32'h1357_9BDF, 4'hA, 2, 1'b1, 32'h0, 1'b0);
    add(1'b0, 32'h0000_0030, 32'h0, 4'hF, 1, 1'b0, 32'h2468_ACE0, 1'b0);
    wait_idle(100);

    // Reset in the middle of an ACCESS with commands still queued.
    add(1'b1, 32'h4000_0200, 32'hFEED_0001, 4'hF, 10, 1'b0, 32'h0, 1'b0);
    add(1'b0, 32'h8000_0204, 32'h0, 4'hF, 10, 1'b0, 32'h9999_0002, 1'b0);
    add(1'b0, 32'hC000_0208, 32'h0, 4'hF, 10, 1'b0, 32'h9999_0003, 1'b0);
    n = 0;
    while (!(Penable && stim_q.size() == 0) && n < 100) begin
      @(posedge Pclk);
      #1;
      n++;
    end
    check("reach_access", Penable, 1'b1);
    rst_cnt = 1;
    repeat (6) @(posedge Pclk);
    #1;
    add(1'b0, 32'h4000_0300, 32'h0, 4'hF, 0, 1'b0, 32'h0F0F_0F0F, 1'b1);
    wait_idle(50);

    // Random traffic with gaps.
    valid_pct = 60;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(9);
      if (r <= 5)      wt = $urandom_range(3);
      else if (r == 6) wt = TMO - 1;
      else if (r == 7) wt = TMO;
      else if (r == 8) wt = 99;
      else             wt = $urandom_range(8, 4);
      add(1'($urandom), $urandom, $urandom, 4'($urandom), wt, ($urandom_range(3) == 0), $urandom, 1'b0);
    end
    wait_idle(5000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
